// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the exhaustive combinational sweep controller.
//   sweep_state_t : controller state encoding (2 bits)
//   VEC_COUNT     : number of input codes walked with the default vector width
//   CNT_W         : width of the settle counter (covers settle times 1..15)
package comb_sweep_pkg;

  localparam int N_IN_DEFAULT   = 6;
  localparam int SETTLE_DEFAULT = 2;
  localparam int VEC_COUNT      = 2 ** N_IN_DEFAULT;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE_W = 2'd1,
    SAMPLE   = 2'd2,
    DONE     = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/comb_sweep_ctrl_settle_timer.sv
// Loadable up/down counter with synchronous clear and a terminal flag.
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear the count to zero (highest priority after reset)
//   load     : load load_val
//   en       : count one step in the direction given by up
//   tc       : high while the count equals TERM-1
module settle_timer
  import comb_sweep_pkg::*;
#(
  parameter int TERM = SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(TERM - 1));

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive stimulus sequencer for a small combinational block.
// Walks vec_out through every code, waits SETTLE cycles per code, then samples
// y_in into table_out[code] and accumulates the number of ones.
//   clk, rst   : clock and synchronous active-high reset
//   start      : begin a sweep (only accepted in IDLE)
//   abort      : leave a running sweep without a done pulse
//   vec_out    : code driven to the block (MSB = input A)
//   y_in       : block output
//   busy       : sweep in progress (including the done cycle)
//   done       : one-cycle completion pulse
//   table_out  : captured truth table, bit k = Y for code k
//   ones_cnt   : number of codes that produced Y=1
//
// state    | meaning
// IDLE     | waiting for start; results held
// SETTLE_W | current code applied, waiting for the block to settle
// SAMPLE   | capture y_in for the current code, then advance or finish
// DONE     | sweep complete, done pulse
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        ones_cnt
);

  sweep_state_t state, state_nx;

  logic tmr_clr, tmr_en, tmr_tc;
  logic sweep_init, sample_en, vec_inc;

  settle_timer #(.TERM(SETTLE)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmr_en),
    .up       (1'b1),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_nx   = state;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    sweep_init = 1'b0;
    sample_en  = 1'b0;
    vec_inc    = 1'b0;
    case (state)
      IDLE: begin
        // abort is meaningless here, so start always wins
        if (start) begin
          sweep_init = 1'b1;
          tmr_clr    = 1'b1;
          state_nx   = SETTLE_W;
        end
      end
      SETTLE_W: begin
        if (abort) begin
          tmr_clr  = 1'b1;
          state_nx = IDLE;
        end else if (tmr_tc) begin
          tmr_clr  = 1'b1;
          state_nx = SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          sample_en = 1'b1;
          // terminal check before the increment so vec_out never wraps
          if (vec_out == {N_IN{1'b1}}) begin
            state_nx = DONE;
          end else begin
            vec_inc  = 1'b1;
            state_nx = SETTLE_W;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec_out   <= '0;
      table_out <= '0;
      ones_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (sweep_init) begin
        vec_out   <= '0;
        table_out <= '0;
        ones_cnt  <= '0;
      end else begin
        if (sample_en) begin
          table_out[vec_out] <= y_in;
          ones_cnt           <= ones_cnt + {{N_IN{1'b0}}, y_in};
        end
        if (vec_inc) begin
          vec_out <= vec_out + N_IN'(1);
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/comb_sweep_ctrl.md
Name: comb_sweep_ctrl

Overview:
Exhaustive stimulus sequencer for the six-input combinational block (inputs A..F, output Y). On a start pulse it walks the input vector through all 2^N_IN codes. For each code it waits a programmable settle time, then samples Y and records it into a truth-table register and a ones counter. This replaces hand-written stimulus sequences and gives a single-shot functional signature of the combinational block.

Parameters:
N_IN, 6, number of combinational inputs; vector width; table depth is 2^N_IN
SETTLE, 2, cycles between applying a code and sampling Y; legal range 1..15

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; honoured only in IDLE
abort  input  1  stop sweep; return to IDLE without asserting done
vec_out  output  N_IN  drive to combinational block; bit N_IN-1 = A ... bit 0 = F
y_in  input  1  Y from combinational block
busy  output  1  high in SETTLE_W, SAMPLE and DONE states
done  output  1  one-cycle pulse when the sweep completes
table_out  output  2^N_IN  bit k = Y sampled with vec_out==k; holds until the next start
ones_cnt  output  N_IN+1  number of codes with Y==1

Behaviour:
- Reset values: state IDLE, vec_out=0, busy=0, done=0, table_out=0, ones_cnt=0, settle counter=0.
- States: IDLE, SETTLE_W, SAMPLE, DONE.
- IDLE, start=1:
  - vec_out<=0, table_out<=0, ones_cnt<=0, cnt<=0.
  - Next state SETTLE_W.
  - busy rises the cycle after start.
- SETTLE_W:
  - cnt increments each cycle.
  - When cnt==SETTLE-1, go to SAMPLE and clear cnt.
  - vec_out is stable for exactly SETTLE cycles before the sample cycle.
- SAMPLE:
  - table_out[vec_out]<=y_in; ones_cnt<=ones_cnt+y_in.
  - If vec_out==2^N_IN-1, go to DONE and hold vec_out.
  - Otherwise vec_out<=vec_out+1 and go to SETTLE_W.
- DONE:
  - done=1 for exactly this cycle; busy=1.
  - Next state IDLE.
- Timing:
  - Per code: SETTLE+1 cycles.
  - Start-accept edge to done-high cycle: 2^N_IN*(SETTLE+1)+1 cycles.
  - Default parameters: 193 cycles.
- Arithmetic: ones_cnt is N_IN+1 bits so the value 2^N_IN (all ones) does not overflow. vec_out never wraps; the terminal check precedes the increment.
- start while not IDLE: ignored. No restart and no effect on the sweep.
- abort in any non-IDLE state: next state IDLE, busy=0, no done pulse. table_out and ones_cnt keep their partial contents; vec_out holds.
- abort and start together in IDLE: start wins. abort has no meaning in IDLE.
- rst mid-sweep: all outputs return to reset values on the next edge, including table_out and ones_cnt.
- After DONE, table_out and ones_cnt stay stable until the next accepted start clears them.
- y_in is sampled only in SAMPLE. Glitches during SETTLE_W are ignored.

Decomposition:
- Shared package comb_sweep_pkg contains:
  - sweep_state_t enum (IDLE, SETTLE_W, SAMPLE, DONE), 2-bit encoding.
  - localparam VEC_COUNT = 2**N_IN.
  - localparam CNT_W = 4, for the settle counter.
- One natural sub-module: settle_timer. It is a loadable down/up counter with clear and a terminal flag (cnt==SETTLE-1). It is reused for later multi-cycle-path checks.
- FSM, vector register, table and ones counter remain in comb_sweep_ctrl.

Test Plan:
- Reset then idle: hold rst 2 cycles, then start=0 for 10 cycles -> all outputs 0, busy=0, done never asserts.
- Full sweep with y_in=vec_out[5] (A), default parameters:
  - Stimulus: 1-cycle start pulse.
  - Response: done pulses exactly 193 cycles after the start edge.
  - table_out=0xFFFFFFFF00000000, ones_cnt=32.
- Reference function Y=(A&~B)|(C&D), behavioural model on vec_out, SETTLE=3:
  - Response: table_out matches the model bit-for-bit; ones_cnt matches the model popcount.
  - Every code is held exactly 3 cycles before its sample.
- Boundaries:
  - y_in tied 1: ones_cnt=64 (7'b1000000); table_out all ones.
  - y_in tied 0: ones_cnt=0.
- start asserted every cycle during a sweep -> sweep is unaffected; exactly one done pulse at cycle 193.
- Abort and reset mid-sweep:
  - abort when vec_out==0x14 -> busy falls next cycle, no done pulse, table bits above 0x13 remain 0.
  - A new start then completes normally.
  - rst at vec_out==0x20 -> all outputs zero the next cycle.
